// File: rtl/req_chan_arbiter.sv
// Request-channel arbiter: four masters share one slave request channel through an IDLE/GRANT/BUSY FSM.
// Optional round-robin priority is enabled by defining REQ_ARB_RR_EN; otherwise priority is fixed at INIT_PTR.
module req_chan_arbiter #(
    parameter logic [1:0] INIT_PTR = 2'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_rq,
    output logic [3:0]   gnt_rq,
    input  logic [3:0]   m_a_valid,
    output logic [3:0]   m_a_ready,
    input  logic [15:0]  m_a_id,
    input  logic [127:0] m_a_addr,
    input  logic [23:0]  m_a_atop,
    output logic         s_a_valid,
    input  logic         s_a_ready,
    output logic [3:0]   s_a_id,
    output logic [31:0]  s_a_addr,
    output logic [5:0]   s_a_atop,
    output logic         busy,
    output logic [1:0]   cur_master
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        BUSY   = 2'd2,
        UNUSED = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] sel;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic       active;
    logic       handshake;

    // First set request at or above base (mod 4) wins; scanning downward lets the nearest one overwrite.
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] idx;
        pick = base;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (req[idx]) pick = idx;
        end
    endfunction

    assign winner    = pick(req_rq, ptr);
    assign active    = (state == GRANT) || (state == BUSY);
    assign handshake = s_a_valid & s_a_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= 2'd0;
            gnt_rq <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_rq) begin
                        sel    <= winner;
                        gnt_rq <= 4'b0001 << winner;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    gnt_rq <= 4'b0000;
                    state  <= BUSY;
                end
                BUSY: begin
                    if (handshake) state <= IDLE;
                end
                default: begin
                    gnt_rq <= 4'b0000;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef REQ_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= INIT_PTR;
        end else if (state == BUSY && handshake) begin
            ptr <= sel + 2'd1;
        end
    end
`else
    assign ptr = INIT_PTR;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        s_a_valid = 1'b0;
        s_a_id    = 4'd0;
        s_a_addr  = 32'd0;
        s_a_atop  = 6'd0;
        m_a_ready = 4'b0000;
        if (active) begin
            s_a_valid      = m_a_valid[sel];
            s_a_id         = m_a_id[{sel, 2'b00} +: 4];
            s_a_addr       = m_a_addr[{sel, 5'b00000} +: 32];
            s_a_atop       = m_a_atop[int'(sel) * 6 +: 6];
            m_a_ready[sel] = s_a_ready;
        end
    end

    assign busy       = active;
    assign cur_master = active ? sel : 2'd0;

endmodule

// File: tb/tb_req_chan_arbiter.sv
// Self-checking bench for req_chan_arbiter: grant scoreboard plus table-driven channel isolation vectors.
// Expected grant orders follow REQ_ARB_RR_EN when defined for the build.
module tb_req_chan_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_rq;
    logic [3:0]   gnt_rq;
    logic [3:0]   m_a_valid;
    logic [3:0]   m_a_ready;
    logic [15:0]  m_a_id;
    logic [127:0] m_a_addr;
    logic [23:0]  m_a_atop;
    logic         s_a_valid;
    logic         s_a_ready;
    logic [3:0]   s_a_id;
    logic [31:0]  s_a_addr;
    logic [5:0]   s_a_atop;
    logic         busy;
    logic [1:0]   cur_master;

`ifdef REQ_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    logic [3:0]  exp_id   [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic [31:0] exp_addr [4] = '{32'h0000_0F00, 32'h1000_1001, 32'h0000_1000, 32'h3000_3000};
    logic [5:0]  exp_atop [4] = '{6'h05, 6'h11, 6'h22, 6'h33};

    typedef struct {
        logic [3:0] valid;
        logic       ready;
        logic       exp_valid;
        logic [3:0] exp_ready;
    } vec_t;
    vec_t vecs[5];

    req_chan_arbiter #(.INIT_PTR(2'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_rq     (req_rq),
        .gnt_rq     (gnt_rq),
        .m_a_valid  (m_a_valid),
        .m_a_ready  (m_a_ready),
        .m_a_id     (m_a_id),
        .m_a_addr   (m_a_addr),
        .m_a_atop   (m_a_atop),
        .s_a_valid  (s_a_valid),
        .s_a_ready  (s_a_ready),
        .s_a_id     (s_a_id),
        .s_a_addr   (s_a_addr),
        .s_a_atop   (s_a_atop),
        .busy       (busy),
        .cur_master (cur_master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every grant pulse seen by the DUT must match the next expected master.
    always @(negedge clk) begin
        if (rst_n && gnt_rq != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", 32'(gnt_rq), 32'd0);
            end else begin
                check("sb_grant", 32'(gnt_rq), 32'(onehot(exp_q.pop_front())));
            end
        end
    end

    task automatic grant_only(input logic [3:0] req, input logic [1:0] exp);
        req_rq = req;
        exp_q.push_back(exp);
        step();
        check("gnt_next_cycle", 32'(gnt_rq), 32'(onehot(exp)));
        check("busy_in_grant", 32'(busy), 32'd1);
        check("cur_master_grant", 32'(cur_master), 32'(exp));
    endtask

    task automatic finish_xfer(input logic [1:0] exp);
        step();
        check("gnt_one_cycle", 32'(gnt_rq), 32'd0);
        m_a_valid = onehot(exp);
        s_a_ready = 1'b1;
        #1;
        check("s_valid", 32'(s_a_valid), 32'd1);
        check("s_addr", s_a_addr, exp_addr[exp]);
        check("s_id", 32'(s_a_id), 32'(exp_id[exp]));
        check("s_atop", 32'(s_a_atop), 32'(exp_atop[exp]));
        check("m_ready_sel", 32'(m_a_ready), 32'(onehot(exp)));
        step();
        check("idle_after_hs", 32'(busy), 32'd0);
        check("cur_master_idle", 32'(cur_master), 32'd0);
        check("m_ready_idle", 32'(m_a_ready), 32'd0);
        m_a_valid = 4'b0000;
        s_a_ready = 1'b0;
    endtask

    task automatic transact(input logic [3:0] req, input logic [1:0] exp);
        grant_only(req, exp);
        finish_xfer(exp);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{valid: 4'b1101, ready: 1'b1, exp_valid: 1'b0, exp_ready: 4'b0010};
        vecs[1] = '{valid: 4'b1101, ready: 1'b0, exp_valid: 1'b0, exp_ready: 4'b0000};
        vecs[2] = '{valid: 4'b0000, ready: 1'b1, exp_valid: 1'b0, exp_ready: 4'b0010};
        vecs[3] = '{valid: 4'b0010, ready: 1'b0, exp_valid: 1'b1, exp_ready: 4'b0000};
        vecs[4] = '{valid: 4'b1111, ready: 1'b1, exp_valid: 1'b1, exp_ready: 4'b0010};

        m_a_id   = {exp_id[3], exp_id[2], exp_id[1], exp_id[0]};
        m_a_addr = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
        m_a_atop = {exp_atop[3], exp_atop[2], exp_atop[1], exp_atop[0]};

        // Reset state with active-looking inputs: everything must stay quiet.
        rst_n = 1'b0;
        req_rq = 4'b0000;
        m_a_valid = 4'b1111;
        s_a_ready = 1'b1;
        #12;
        check("rst_gnt", 32'(gnt_rq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_master", 32'(cur_master), 32'd0);
        check("rst_s_valid", 32'(s_a_valid), 32'd0);
        check("rst_s_addr", s_a_addr, 32'd0);
        check("rst_m_ready", 32'(m_a_ready), 32'd0);
        m_a_valid = 4'b0000;
        s_a_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("idle_no_req", 32'(busy), 32'd0);

        // Single request from master 2.
        transact(4'b0100, 2'd2);
        req_rq = 4'b0000;
        reset_pulse();

        // Contention with all requests held.
        for (int i = 0; i < 5; i++) begin
            transact(4'b1111, RR ? 2'(i) : 2'd0);
        end
        req_rq = 4'b0000;

        // Pointer wrap: after master 2, pointer sits at 3 in round-robin mode.
        transact(4'b0100, 2'd2);
        transact(4'b1001, RR ? 2'd3 : 2'd0);
        transact(4'b1001, 2'd0);
        req_rq = 4'b0000;

        // Backpressure on master 1 with competing requests.
        grant_only(4'b0010, 2'd1);
        req_rq = 4'b1010;
        s_a_ready = 1'b0;
        m_a_valid = 4'b0010;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_cur_master", 32'(cur_master), 32'd1);
            check("bp_m_ready", 32'(m_a_ready), 32'd0);
            check("bp_no_gnt", 32'(gnt_rq), 32'd0);
            check("bp_s_valid", 32'(s_a_valid), 32'd1);
            step();
        end

        // Isolation vectors while master 1 holds the channel; last row completes the transfer.
        for (int i = 0; i < 5; i++) begin
            m_a_valid = vecs[i].valid;
            s_a_ready = vecs[i].ready;
            #1;
            check("iso_s_valid", 32'(s_a_valid), 32'(vecs[i].exp_valid));
            check("iso_m_ready", 32'(m_a_ready), 32'(vecs[i].exp_ready));
            check("iso_busy", 32'(busy), 32'd1);
            check("iso_s_addr", s_a_addr, exp_addr[1]);
            if (i == 4) req_rq = 4'b0000;
            step();
        end
        check("iso_done_idle", 32'(busy), 32'd0);
        m_a_valid = 4'b0000;
        s_a_ready = 1'b0;

        // Reset mid-BUSY aborts the transfer and restores the initial pointer.
        grant_only(4'b0001, 2'd0);
        req_rq = 4'b0000;
        step();
        m_a_valid = 4'b0001;
        s_a_ready = 1'b1;
        #1;
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cur_master", 32'(cur_master), 32'd0);
        check("abort_s_valid", 32'(s_a_valid), 32'd0);
        check("abort_m_ready", 32'(m_a_ready), 32'd0);
        check("abort_gnt", 32'(gnt_rq), 32'd0);
        m_a_valid = 4'b0000;
        s_a_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        transact(4'b1111, 2'd0);
        req_rq = 4'b0000;
        step();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_chan_arbiter.md
REQ_CHAN_ARBITER -- requirements
Module: req_chan_arbiter

Interface
REQ-001 Parameter INIT_PTR, default 2'd0: master index that has highest priority after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_rq  input  4  per-master request, bit i from master i.
REQ-005 gnt_rq  output  4  per-master grant, one-hot, registered.
REQ-006 m_a_valid  input  4  per-master request-channel valid.
REQ-007 m_a_ready  output  4  per-master ready, routed from slave.
REQ-008 m_a_id  input  16  per-master id, master i on bits [4i+3:4i].
REQ-009 m_a_addr  input  128  per-master address, master i on bits [32i+31:32i].
REQ-010 m_a_atop  input  24  per-master atop, master i on bits [6i+5:6i].
REQ-011 s_a_valid / s_a_ready  output / input  1 / 1  shared request channel handshake.
REQ-012 s_a_id / s_a_addr / s_a_atop  output  4 / 32 / 6  shared request channel payload.
REQ-013 busy  output  1  high in GRANT or BUSY.
REQ-014 cur_master  output  2  index of the selected master; 0 in IDLE.

Function
REQ-015 The arbiter SHALL implement states IDLE, GRANT and BUSY, with a 2-bit state encoding; the fourth code SHALL return to IDLE.
REQ-016 IDLE: if any req_rq bit is 1, the arbiter SHALL pick a winner, register it in sel, assert gnt_rq[sel] for the next cycle, and go to GRANT. Otherwise it SHALL stay in IDLE.
REQ-017 GRANT: gnt_rq SHALL be high for exactly this one cycle; the next state SHALL be BUSY unconditionally.
REQ-018 BUSY: the arbiter SHALL stay in BUSY until s_a_valid & s_a_ready, then go to IDLE on the next edge.
REQ-019 The earliest new grant after a handshake SHALL be 2 cycles later, and request-to-grant latency SHALL be 1 cycle from IDLE.
REQ-020 In GRANT and BUSY, s_a_valid/s_a_id/s_a_addr/s_a_atop SHALL equal the sel master's fields combinationally, and m_a_ready[sel] SHALL equal s_a_ready.
REQ-021 All other m_a_ready bits SHALL be 0. In IDLE all s_a_* outputs and all m_a_ready bits SHALL be 0.
REQ-022 Requests arriving in GRANT/BUSY SHALL be ignored until IDLE; req_rq SHALL be sampled only in IDLE.
REQ-023 A m_a_valid from an unselected master SHALL never reach s_a_valid.
REQ-024 Winner selection SHALL scan from the priority pointer ptr upward modulo 4, and the first set req_rq bit SHALL win.
REQ-025 On each handshake ptr SHALL update per REQ-033; index arithmetic SHALL be 2-bit, with 3+1 wrapping to 0.
REQ-026 If the sel master drops m_a_valid in BUSY, the arbiter SHALL remain in BUSY (no timeout).

Reset
REQ-027 On rst_n low, state SHALL go to IDLE asynchronously, with gnt_rq=4'b0000, sel=0, ptr=INIT_PTR.
REQ-028 During reset, busy=0, cur_master=0, and all s_a_* and m_a_ready outputs SHALL be 0.
REQ-029 Reset asserted mid-GRANT or mid-BUSY SHALL abort the transfer, with no handshake recorded and no ptr update.
REQ-030 The first arbitration after reset deassertion SHALL occur on the first rising edge with any req_rq set.

Configuration
REQ-031 The macro name SHALL be REQ_ARB_RR_EN.
REQ-032 Without REQ_ARB_RR_EN, ptr SHALL be held at INIT_PTR permanently (fixed priority), and no ptr register update logic SHALL exist.
REQ-033 With REQ_ARB_RR_EN, ptr SHALL become sel+1 (mod 4) on the handshake edge in BUSY (round-robin).

Verification
REQ-034 Single request: reset, req_rq=4'b0100 -> gnt_rq=4'b0100 next cycle for 1 cycle; then m_a_valid[2]=1, m_a_addr[95:64]=32'h0000_1000 -> s_a_addr=32'h0000_1000, s_a_id=m_a_id[11:8]; s_a_ready=1 -> IDLE next cycle.
REQ-035 Contention: req_rq=4'b1111 held, slave always ready, REQ_ARB_RR_EN defined -> grant order 0,1,2,3,0; undefined -> grants to master 0 only.
REQ-036 Backpressure: in BUSY with s_a_ready=0 for 5 cycles -> state stays BUSY, m_a_ready[sel]=0, no new gnt_rq despite req_rq=4'b1010.
REQ-037 Isolation: sel=1, m_a_valid=4'b1101 -> s_a_valid=0 until m_a_valid[1]=1; m_a_ready[0,2,3]=0 throughout.
REQ-038 Wrap/reset: RR enabled, ptr=3, req_rq=4'b1001 -> master 3 granted, then master 0; rst_n pulsed low in BUSY -> all outputs 0 immediately, next grant follows INIT_PTR.
